// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary conversion helpers for the gray counter.
// The helpers work on 16-bit values, which is the widest legal counter.
// Narrower codes are passed zero-extended.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 3;
  localparam int GRAY_MAX_WIDTH     = 16;

  // Binary to reflected Gray code.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary.
  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
    logic [GRAY_MAX_WIDTH-1:0] bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// Purely combinational binary-to-Gray converter of parameterizable width.
module gray_bin2gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // Adjacent binary bits XORed.
  // The MSB passes through unchanged.
  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray.sv
// Synchronous Gray-code up-counter with a sticky wrap flag.
// The state is a binary count.
// The next Gray value is derived from the next binary count and then registered.
// As a result, Output never has a combinational path from the inputs.
// Optional feature: define GRAY_BIN_OUT_EN to expose the registered binary count on BinOut.
// WIDTH must be in the range 2..16.
module gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
`ifdef GRAY_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] BinOut
`endif
);

  localparam logic [WIDTH-1:0] LAST_BIN = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;

  // Next binary count and sticky wrap flag.
  // Holding keeps bin_d equal to bin_q.
  // Because of that, the converted Gray value also holds.
  always_comb begin
    bin_d = bin_q;
    ovf_d = ovf_q;
    if (En) begin
      bin_d = bin_q + 1'b1;
      if (bin_q == LAST_BIN) begin
        ovf_d = 1'b1;
      end
    end
  end

  gray_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  // State register.
  // Reset wins over En.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Output   = gray_q;
  assign Overflow = ovf_q;

`ifdef GRAY_BIN_OUT_EN
  assign BinOut = bin_q;
`endif

endmodule

// File: tb/tb_gray.sv
// Directed-vector bench for the gray counter, using a queue scoreboard.
// The stimulus process drives the inputs on the falling edge.
// At the same time, it pushes the hand-computed Output/Overflow expected after the next rising edge.
// The monitor process pops and compares each entry 1 ns after every rising edge.
module tb_gray;
  import gray_pkg::*;

  localparam int W = GRAY_DEFAULT_WIDTH;

  typedef struct {
    logic [W-1:0] g;
    logic         o;
    logic         step;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] out;
  logic         ovf;
`ifdef GRAY_BIN_OUT_EN
  logic [W-1:0] bin_out;
`endif

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] prev_out = '0;
  logic         prev_valid = 1'b0;

  gray #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Reset    (rst),
    .En       (en),
    .Output   (out),
    .Overflow (ovf)
`ifdef GRAY_BIN_OUT_EN
    ,
    .BinOut   (bin_out)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry is consumed per clock while the queue is non-empty.
  initial begin
    exp_t e;
    logic [GRAY_MAX_WIDTH-1:0] wide;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (out !== e.g || ovf !== e.o) begin
          n_err++;
          $display("FAIL out_ovf vec %0d: got %b/%b, expected %b/%b", n_vec, out, ovf, e.g, e.o);
        end else begin
          $display("vec %0d ok: out=%b ovf=%b", n_vec, out, ovf);
        end
        if (e.step && prev_valid && $countones(out ^ prev_out) != 1) begin
          n_err++;
          $display("FAIL one_bit vec %0d: changed bits %0d (from %b to %b), expected 1",
                   n_vec, $countones(out ^ prev_out), prev_out, out);
        end
`ifdef GRAY_BIN_OUT_EN
        wide = gray2bin(GRAY_MAX_WIDTH'(e.g));
        if (bin_out !== wide[W-1:0]) begin
          n_err++;
          $display("FAIL bin_out vec %0d: got %b, expected %b", n_vec, bin_out, wide[W-1:0]);
        end
        wide = bin2gray(GRAY_MAX_WIDTH'(bin_out));
        if (wide[W-1:0] !== out) begin
          n_err++;
          $display("FAIL bin_align vec %0d: bin2gray(BinOut)=%b, Output=%b", n_vec, wide[W-1:0], out);
        end
`else
        wide = '0;
`endif
        prev_out   = out;
        prev_valid = 1'b1;
      end
    end
  end

  // Drive one clock of stimulus and record what must appear after that edge.
  task automatic apply(input logic r, input logic e, input logic [W-1:0] g, input logic o);
    exp_t x;
    @(negedge clk);
    rst    = r;
    en     = e;
    x.g    = g;
    x.o    = o;
    x.step = e && !r;
    exp_q.push_back(x);
  endtask

  // Stimulus.
  initial begin
    // Reset, then hold with En low for 100 ns.
    apply(1, 0, 3'b000, 0);
    for (int i = 0; i < 10; i++) apply(0, 0, 3'b000, 0);

    // First full lap.
    // Overflow rises together with the wrap to 000.
    apply(0, 1, 3'b001, 0);
    apply(0, 1, 3'b011, 0);
    apply(0, 1, 3'b010, 0);
    apply(0, 1, 3'b110, 0);
    apply(0, 1, 3'b111, 0);
    apply(0, 1, 3'b101, 0);
    apply(0, 1, 3'b100, 0);
    apply(0, 1, 3'b000, 1);

    // Keep counting; Overflow stays sticky.
    apply(0, 1, 3'b001, 1);
    apply(0, 1, 3'b011, 1);
    apply(0, 1, 3'b010, 1);
    apply(0, 1, 3'b110, 1);
    apply(0, 1, 3'b111, 1);

    // Reset mid-count at 111, then count to 010.
    apply(1, 1, 3'b000, 0);
    apply(0, 1, 3'b001, 0);
    apply(0, 1, 3'b011, 0);
    apply(0, 1, 3'b010, 0);

    // Reset with En high at 010; reset wins, then counting resumes.
    apply(1, 1, 3'b000, 0);
    apply(0, 1, 3'b001, 0);
    apply(0, 1, 3'b011, 0);

    // Toggle En 1,0,1,0 from 000.
    apply(1, 0, 3'b000, 0);
    apply(0, 1, 3'b001, 0);
    apply(0, 0, 3'b001, 0);
    apply(0, 1, 3'b011, 0);
    apply(0, 0, 3'b011, 0);

    // Through a second wrap.
    // After that, hold with En low; Overflow stays set.
    apply(0, 1, 3'b010, 0);
    apply(0, 1, 3'b110, 0);
    apply(0, 1, 3'b111, 0);
    apply(0, 1, 3'b101, 0);
    apply(0, 1, 3'b100, 0);
    apply(0, 1, 3'b000, 1);
    apply(0, 1, 3'b001, 1);
    apply(0, 1, 3'b011, 1);
    apply(0, 0, 3'b011, 1);
    apply(0, 0, 3'b011, 1);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
